// File: rtl/sq_arb_pkg.sv
// Shared types and defaults for the squarer-sharing arbiter.
// Latency: none (declarations only). Backpressure: not applicable.
// Build option SQ_ARB_STATS_EN is consumed by the top, not here.
package sq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 3;

    // Requester index width; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sq_core.sv
// Combinational squarer: out = enb ? in*in : 0, full 2*W-bit result.
// Latency: 0 cycles. Backpressure: none, purely combinational.
// Build option SQ_ARB_STATS_EN has no effect on this block.
module sq_core #(
    parameter int W = 3
) (
    input  logic [W-1:0]   in,
    input  logic           enb,
    output logic [2*W-1:0] out
);

    logic [2*W-1:0] w_ext;

    assign w_ext = {{W{1'b0}}, in};
    assign out   = enb ? (w_ext * w_ext) : '0;

endmodule

// File: rtl/square_share_arbiter.sv
// Round-robin share of one squarer among NREQ valid/ready requesters; SQ_ARB_STATS_EN adds grant_cnt.
// Latency: accept cycle -> rsp_valid two cycles later; one result per three cycles at best.
// Backpressure: rsp_ready low parks the FSM in RESP and withholds all req_ready grants.
module square_share_arbiter
    import sq_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ*W-1:0]               req_in,
    output logic [NREQ-1:0]                 req_ready,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [2*W-1:0]                  rsp_data,
    output logic [sq_arb_pkg::id_w(NREQ)-1:0] rsp_id
`ifdef SQ_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0]               grant_cnt
`endif
);

    localparam int IDW = id_w(NREQ);

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_gid;
    logic [W-1:0]    r_op;
    logic            r_rsp_valid;
    logic [2*W-1:0]  r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;

    logic            w_any;
    logic [IDW-1:0]  w_gidx;
    logic [NREQ-1:0] w_grant_vec;
    logic            w_sq_en;
    logic [2*W-1:0]  w_sq_out;

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        int v_idx;
        v_idx  = 0;
        w_any  = 1'b0;
        w_gidx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_any && req_valid[v_idx]) begin
                w_any  = 1'b1;
                w_gidx = IDW'(v_idx);
            end
        end
    end

    // Gated by rst_n so no accept strobe leaks out while reset is held.
    always_comb begin
        w_grant_vec = '0;
        if (rst_n && (r_state == IDLE) && w_any) begin
            w_grant_vec[w_gidx] = 1'b1;
        end
    end

    assign w_sq_en = (r_state == CALC);

    sq_core #(.W(W)) u_sq_core (
        .in  (r_op),
        .enb (w_sq_en),
        .out (w_sq_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= IDW'(NREQ - 1);
            r_gid       <= '0;
            r_op        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op     <= req_in[w_gidx*W +: W];
                        r_gid    <= w_gidx;
                        r_rr_ptr <= w_gidx;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_rsp_data  <= w_sq_out;
                    r_rsp_id    <= r_gid;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_grant_vec;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef SQ_ARB_STATS_EN
    logic [NREQ*8-1:0] r_grant_cnt;

    // Per-requester completed-response counters, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else if ((r_state == RESP) && rsp_ready) begin
            if (r_grant_cnt[r_rsp_id*8 +: 8] != 8'hFF) begin
                r_grant_cnt[r_rsp_id*8 +: 8] <= r_grant_cnt[r_rsp_id*8 +: 8] + 8'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_square_share_arbiter.sv
// Randomised and directed bench for square_share_arbiter against a transaction-level model.
module tb_square_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_in;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_data;
    logic [1:0]  rsp_id;
`ifdef SQ_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    square_share_arbiter #(.NREQ(4), .W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_in    (req_in),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef SQ_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: one outstanding job at a time; m_cd counts edges until its result shows.
    bit   m_busy;
    int   m_cd, m_id, m_res, m_last, m_acc;
    int   m_cnt[4];
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [5:0] e_dat;
    logic [1:0] e_id;

    function void model_reset();
        m_busy = 0; m_cd = 0; m_id = 0; m_res = 0; m_last = 3; m_acc = -1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endfunction

    function int m_pick();
        if (!rst_n || m_busy) return -1;
        for (int k = 1; k <= 4; k++) begin
            if (req_valid[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    function void m_expect();
        int p;
        p = m_pick();
        e_rdy = '0;
        if (p >= 0) e_rdy[p] = 1'b1;
        e_vld = m_busy && (m_cd == 0);
        e_dat = 6'(m_res);
        e_id  = 2'(m_id);
    endfunction

    // Advance one clock: update model from pre-edge inputs, then release the accepted requester.
    task automatic tick();
        int p, o;
        m_acc = -1;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy && m_cd == 0) begin
            if (rsp_ready) begin
                m_busy = 0;
                if (m_cnt[m_id] < 255) m_cnt[m_id]++;
            end
        end else if (m_busy) begin
            m_cd--;
        end else begin
            p = m_pick();
            if (p >= 0) begin
                o = int'(req_in[p*3 +: 3]);
                m_busy = 1; m_cd = 1; m_id = p; m_res = o * o; m_last = p; m_acc = p;
            end
        end
        @(posedge clk);
        #1;
        if (m_acc >= 0) req_valid[m_acc] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_in = {3'd7, 3'd3, 3'd2, 3'd1};
        rsp_ready = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared += 4;
            if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL reset req_ready got %b want 0000", req_ready); end
            if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset rsp_valid got %b want 0", rsp_valid); end
            if (rsp_data !== 6'd0) begin mismatched++; $display("FAIL reset rsp_data got %0d want 0", rsp_data); end
            if (rsp_id !== 2'd0) begin mismatched++; $display("FAIL reset rsp_id got %0d want 0", rsp_id); end
            tick();
        end
        rst_n = 1'b1;
        #1;
        compared++;
        if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL reset_release req_ready got %b want 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0001;
        req_in = {3'd0, 3'd0, 3'd0, 3'd5};
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            m_expect();
            compared += 2;
            if (req_ready !== e_rdy) begin mismatched++; $display("FAIL single req_ready got %b want %b", req_ready, e_rdy); end
            if (rsp_valid !== e_vld) begin mismatched++; $display("FAIL single rsp_valid got %b want %b", rsp_valid, e_vld); end
            if (e_vld) begin
                compared += 2;
                if (rsp_data !== e_dat) begin mismatched++; $display("FAIL single rsp_data got %0d want %0d", rsp_data, e_dat); end
                if (rsp_id !== e_id) begin mismatched++; $display("FAIL single rsp_id got %0d want %0d", rsp_id, e_id); end
            end
            if (c == 0) begin
                compared++;
                if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL single_t0 req_ready got %b want 0001", req_ready); end
            end
            if (c == 2) begin
                compared += 3;
                if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL single_t2 rsp_valid got %b want 1", rsp_valid); end
                if (rsp_data !== 6'd25) begin mismatched++; $display("FAIL single_t2 rsp_data got %0d want 25", rsp_data); end
                if (rsp_id !== 2'd0) begin mismatched++; $display("FAIL single_t2 rsp_id got %0d want 0", rsp_id); end
            end
            tick();
        end
    endtask

    task automatic test_all_four();
        int got_id[$], got_dat[$];
        int want_id[5]  = '{0, 1, 2, 3, 1};
        int want_dat[5] = '{1, 4, 9, 49, 36};
        bit reissued = 0;
        apply_reset();
        req_valid = 4'hF;
        req_in = {3'd7, 3'd3, 3'd2, 3'd1};
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && got_id.size() < 5; c++) begin
            #1;
            m_expect();
            compared += 2;
            if (req_ready !== e_rdy) begin mismatched++; $display("FAIL all4 req_ready got %b want %b", req_ready, e_rdy); end
            if (rsp_valid !== e_vld) begin mismatched++; $display("FAIL all4 rsp_valid got %b want %b", rsp_valid, e_vld); end
            if (e_vld) begin
                compared += 2;
                if (rsp_data !== e_dat) begin mismatched++; $display("FAIL all4 rsp_data got %0d want %0d", rsp_data, e_dat); end
                if (rsp_id !== e_id) begin mismatched++; $display("FAIL all4 rsp_id got %0d want %0d", rsp_id, e_id); end
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                got_id.push_back(int'(rsp_id));
                got_dat.push_back(int'(rsp_data));
            end
            tick();
            if (got_id.size() == 4 && !reissued) begin
                req_in[5:3] = 3'd6;
                req_valid[1] = 1'b1;
                reissued = 1;
            end
        end
        compared++;
        if (got_id.size() != 5) begin
            mismatched++;
            $display("FAIL all4_count responses got %0d want 5", got_id.size());
        end
        for (int i = 0; i < 5 && i < got_id.size(); i++) begin
            compared += 2;
            if (got_id[i] != want_id[i]) begin mismatched++; $display("FAIL all4_order[%0d] id got %0d want %0d", i, got_id[i], want_id[i]); end
            if (got_dat[i] != want_dat[i]) begin mismatched++; $display("FAIL all4_order[%0d] data got %0d want %0d", i, got_dat[i], want_dat[i]); end
        end
`ifdef SQ_ARB_STATS_EN
        compared++;
        if (grant_cnt !== 32'h01010201) begin mismatched++; $display("FAIL all4_stats grant_cnt got %h want 01010201", grant_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        int c;
        rsp_ready = 1'b0;
        req_valid = 4'b0101;
        req_in = {3'd0, 3'd4, 3'd0, 3'd3};
        c = 0;
        while (!(m_busy && m_cd == 0) && c < 10) begin
            #1;
            m_expect();
            compared++;
            if (req_ready !== e_rdy) begin mismatched++; $display("FAIL bp_start req_ready got %b want %b", req_ready, e_rdy); end
            tick();
            c++;
        end
        for (int h = 0; h < 5; h++) begin
            #1;
            m_expect();
            compared += 4;
            if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL bp_hold req_ready got %b want 0000", req_ready); end
            if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold rsp_valid got %b want 1", rsp_valid); end
            if (rsp_data !== e_dat) begin mismatched++; $display("FAIL bp_hold rsp_data got %0d want %0d", rsp_data, e_dat); end
            if (rsp_id !== e_id) begin mismatched++; $display("FAIL bp_hold rsp_id got %0d want %0d", rsp_id, e_id); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tick();
        #1;
        compared++;
        if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release rsp_valid got %b want 0", rsp_valid); end
        for (int d = 0; d < 12; d++) begin
            m_expect();
            compared += 2;
            if (req_ready !== e_rdy) begin mismatched++; $display("FAIL bp_drain req_ready got %b want %b", req_ready, e_rdy); end
            if (rsp_valid !== e_vld) begin mismatched++; $display("FAIL bp_drain rsp_valid got %b want %b", rsp_valid, e_vld); end
            if (e_vld) begin
                compared += 2;
                if (rsp_data !== e_dat) begin mismatched++; $display("FAIL bp_drain rsp_data got %0d want %0d", rsp_data, e_dat); end
                if (rsp_id !== e_id) begin mismatched++; $display("FAIL bp_drain rsp_id got %0d want %0d", rsp_id, e_id); end
            end
            tick();
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int got_id[$], got_dat[$];
        apply_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        req_in = {3'd0, 3'd5, 3'd0, 3'd0};
        #1;
        compared++;
        if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL rmid_grant req_ready got %b want 0100", req_ready); end
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            compared += 2;
            if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_reset rsp_valid got %b want 0", rsp_valid); end
            if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL rmid_reset req_ready got %b want 0000", req_ready); end
            tick();
        end
        rst_n = 1'b1;
        req_valid = 4'b0101;
        req_in = {3'd0, 3'd5, 3'd0, 3'd2};
        #1;
        compared++;
        if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL rmid_after req_ready got %b want 0001", req_ready); end
        for (int c = 0; c < 12; c++) begin
            m_expect();
            compared += 1;
            if (rsp_valid !== e_vld) begin mismatched++; $display("FAIL rmid_run rsp_valid got %b want %b", rsp_valid, e_vld); end
            if (rsp_valid === 1'b1) begin
                got_id.push_back(int'(rsp_id));
                got_dat.push_back(int'(rsp_data));
            end
            tick();
            #1;
        end
        compared++;
        if (got_id.size() != 2) begin
            mismatched++;
            $display("FAIL rmid_count responses got %0d want 2", got_id.size());
        end else begin
            compared += 3;
            if (got_id[0] != 0) begin mismatched++; $display("FAIL rmid_first id got %0d want 0", got_id[0]); end
            if (got_dat[0] != 4) begin mismatched++; $display("FAIL rmid_first data got %0d want 4", got_dat[0]); end
            if (got_dat[1] != 25) begin mismatched++; $display("FAIL rmid_second data got %0d want 25", got_dat[1]); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            #1;
            m_expect();
            compared += 2;
            if (req_ready !== e_rdy) begin mismatched++; $display("FAIL rand req_ready got %b want %b", req_ready, e_rdy); end
            if (rsp_valid !== e_vld) begin mismatched++; $display("FAIL rand rsp_valid got %b want %b", rsp_valid, e_vld); end
            if (e_vld) begin
                compared += 2;
                if (rsp_data !== e_dat) begin mismatched++; $display("FAIL rand rsp_data got %0d want %0d", rsp_data, e_dat); end
                if (rsp_id !== e_id) begin mismatched++; $display("FAIL rand rsp_id got %0d want %0d", rsp_id, e_id); end
            end
            tick();
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_in[i*3 +: 3] = 3'($urandom_range(7));
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
`ifdef SQ_ARB_STATS_EN
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (grant_cnt[i*8 +: 8] !== 8'(m_cnt[i])) begin mismatched++; $display("FAIL rand_stats[%0d] got %0d want %0d", i, grant_cnt[i*8 +: 8], m_cnt[i]); end
        end
`endif
    endtask

`ifdef SQ_ARB_STATS_EN
    task automatic test_stats_saturate();
        int done3 = 0;
        apply_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 1200 && done3 < 300; c++) begin
            if (!req_valid[3]) begin
                req_in[11:9] = 3'($urandom_range(7));
                req_valid[3] = 1'b1;
            end
            #1;
            if (rsp_valid === 1'b1) done3++;
            tick();
        end
        req_valid = '0;
        #1;
        compared += 3;
        if (done3 != 300) begin mismatched++; $display("FAIL sat_count responses got %0d want 300", done3); end
        if (grant_cnt[31:24] !== 8'd255) begin mismatched++; $display("FAIL sat_cnt3 got %0d want 255", grant_cnt[31:24]); end
        if (grant_cnt[23:0] !== 24'd0) begin mismatched++; $display("FAIL sat_others got %h want 000000", grant_cnt[23:0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef SQ_ARB_STATS_EN
        test_stats_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
